// File: rtl/counter_pkg.sv
// Shared types for the counter family: bound behaviour selector used by
// prog_counter and later counter variants.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Enable prescaler: emits one STEP per PRESCALE enabled cycles.
// CLR restarts the prescale window and suppresses the step.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic EN,
    input  logic CLR,
    output logic STEP
);

    localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    logic [PC_W-1:0] pc;

    assign STEP = EN && !CLR && (pc == PC_LAST);

    // EN low freezes pc so a paused window resumes without losing progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (CLR) begin
            pc <= '0;
        end else if (EN) begin
            pc <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Up/down counter with programmable terminal value, load clamp,
// wrap/saturate bound handling, prescaled enable and terminal-count pulse.
module prog_counter
    import counter_pkg::*;
#(
    parameter int        WIDTH    = 8,
    parameter int        PRESCALE = 1,
    parameter cnt_mode_e MODE     = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic [WIDTH-1:0] TOP,
    output logic [WIDTH-1:0] CNT,
    output logic             MAX,
    output logic             ZERO,
    output logic             TC
);

    logic step;
    logic up_bound;
    logic dn_bound;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .EN   (EN),
        .CLR  (LD),
        .STEP (step)
    );

    // >= so a count left above a lowered TOP is still treated as at bound
    assign up_bound = (CNT >= TOP);
    assign dn_bound = (CNT == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CNT <= '0;
            TC  <= 1'b0;
        end else if (LD) begin
            CNT <= (LD_VAL > TOP) ? TOP : LD_VAL;
            TC  <= 1'b0;
        end else if (step) begin
            if (UP) begin
                if (up_bound) begin
                    CNT <= (MODE == CNT_SAT) ? TOP : '0;
                    TC  <= 1'b1;
                end else begin
                    CNT <= CNT + WIDTH'(1);
                    TC  <= 1'b0;
                end
            end else begin
                if (dn_bound) begin
                    CNT <= (MODE == CNT_SAT) ? '0 : TOP;
                    TC  <= 1'b1;
                end else begin
                    CNT <= CNT - WIDTH'(1);
                    TC  <= 1'b0;
                end
            end
        end else begin
            TC <= 1'b0;
        end
    end

    assign MAX  = (CNT == TOP);
    assign ZERO = (CNT == '0);

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: three instances (wrap/1, sat/1, wrap/3) share stimulus
// and are compared against an arithmetic reference model.
module tb_prog_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b1, ld = 1'b0;
    logic [3:0] ldv = '0, top = 4'd9;
    logic [3:0] cnt_o [3];
    logic       tc_o [3], max_o [3], zero_o [3];

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: count, enabled cycles since last step, pulse
    int m_cnt [3];
    int m_pc  [3];
    bit m_tc  [3];
    int PS    [3] = '{1, 1, 3};
    bit SAT   [3] = '{0, 1, 0};

    logic [6:0] got, exp;

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(4), .PRESCALE(1), .MODE(CNT_WRAP)) dut_w (
        .clk(clk), .rst_n(rst_n), .EN(en), .UP(up), .LD(ld), .LD_VAL(ldv), .TOP(top),
        .CNT(cnt_o[0]), .MAX(max_o[0]), .ZERO(zero_o[0]), .TC(tc_o[0]));
    prog_counter #(.WIDTH(4), .PRESCALE(1), .MODE(CNT_SAT)) dut_s (
        .clk(clk), .rst_n(rst_n), .EN(en), .UP(up), .LD(ld), .LD_VAL(ldv), .TOP(top),
        .CNT(cnt_o[1]), .MAX(max_o[1]), .ZERO(zero_o[1]), .TC(tc_o[1]));
    prog_counter #(.WIDTH(4), .PRESCALE(3), .MODE(CNT_WRAP)) dut_p (
        .clk(clk), .rst_n(rst_n), .EN(en), .UP(up), .LD(ld), .LD_VAL(ldv), .TOP(top),
        .CNT(cnt_o[2]), .MAX(max_o[2]), .ZERO(zero_o[2]), .TC(tc_o[2]));

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_pc[k] = 0; m_tc[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit st;
        for (int k = 0; k < 3; k++) begin
            if (ld) begin
                m_cnt[k] = (ldv > top) ? int'(top) : int'(ldv);
                m_pc[k]  = 0;
                m_tc[k]  = 0;
            end else begin
                st = 0;
                if (en) begin
                    m_pc[k]++;
                    if (m_pc[k] == PS[k]) begin m_pc[k] = 0; st = 1; end
                end
                m_tc[k] = 0;
                if (st && up) begin
                    if (m_cnt[k] >= int'(top)) begin
                        m_cnt[k] = SAT[k] ? int'(top) : 0; m_tc[k] = 1;
                    end else m_cnt[k]++;
                end else if (st) begin
                    if (m_cnt[k] == 0) begin
                        m_cnt[k] = SAT[k] ? 0 : int'(top); m_tc[k] = 1;
                    end else m_cnt[k]--;
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 0; ld = 0; up = 1; top = 4'd9;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            got = {cnt_o[k], tc_o[k], max_o[k], zero_o[k]};
            if (got !== 7'b0000_0_0_1) begin
                n_fail++; $display("FAIL reset dut%0d: got %b exp 0000001 (cnt,tc,max,zero)", k, got);
            end
        end
        top = 4'd0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (max_o[k] !== 1'b1) begin
                n_fail++; $display("FAIL reset_max_top0 dut%0d: got %b exp 1", k, max_o[k]);
            end
        end
        top = 4'd9;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        en = 0; up = 1; ld = 0; top = 4'd9;
        do_reset();
        en = 1;
        for (int i = 1; i <= 11; i++) begin
            adv();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                got = {cnt_o[k], tc_o[k], max_o[k], zero_o[k]};
                exp = {4'(m_cnt[k]), m_tc[k], m_cnt[k] == int'(top), m_cnt[k] == 0};
                if (got !== exp) begin
                    n_fail++; $display("FAIL wrap_up dut%0d edge%0d: got %b exp %b", k, i, got, exp);
                end
            end
            n_tests++;
            exp = {4'(i % 10), 1'(i == 10), 1'(i == 9), 1'(i % 10 == 0)};
            got = {cnt_o[0], tc_o[0], max_o[0], zero_o[0]};
            if (got !== exp) begin
                n_fail++; $display("FAIL wrap_up_const edge%0d: got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_down();
        en = 0; up = 0; ld = 0; top = 4'd5;
        do_reset();
        en = 1;
        for (int i = 1; i <= 4; i++) begin
            adv();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                got = {cnt_o[k], tc_o[k], max_o[k], zero_o[k]};
                exp = {4'(m_cnt[k]), m_tc[k], m_cnt[k] == int'(top), m_cnt[k] == 0};
                if (got !== exp) begin
                    n_fail++; $display("FAIL down dut%0d edge%0d: got %b exp %b", k, i, got, exp);
                end
            end
            n_tests++;
            if (cnt_o[1] !== 4'd0 || tc_o[1] !== 1'b1) begin
                n_fail++; $display("FAIL down_sat_pin edge%0d: got cnt=%0d tc=%b exp cnt=0 tc=1", i, cnt_o[1], tc_o[1]);
            end
            if (i == 1) begin
                n_tests++;
                if (cnt_o[0] !== 4'd5 || tc_o[0] !== 1'b1) begin
                    n_fail++; $display("FAIL down_wrap: got cnt=%0d tc=%b exp cnt=5 tc=1", cnt_o[0], tc_o[0]);
                end
            end
        end
    endtask

    task automatic test_prescale();
        en = 0; up = 1; ld = 0; top = 4'd15;
        do_reset();
        en = 1;
        for (int i = 1; i <= 13; i++) begin
            if (i == 8) en = 0;
            if (i == 12) en = 1;
            adv();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                got = {cnt_o[k], tc_o[k], max_o[k], zero_o[k]};
                exp = {4'(m_cnt[k]), m_tc[k], m_cnt[k] == int'(top), m_cnt[k] == 0};
                if (got !== exp) begin
                    n_fail++; $display("FAIL prescale dut%0d edge%0d: got %b exp %b", k, i, got, exp);
                end
            end
            // steps at edges 3 and 6; pause 8..11 leaves one enabled cycle banked
            n_tests++;
            exp = 7'((i >= 13) ? 3 : (i >= 6) ? 2 : (i >= 3) ? 1 : 0);
            if (cnt_o[2] !== exp[3:0]) begin
                n_fail++; $display("FAIL prescale_const edge%0d: got %0d exp %0d", i, cnt_o[2], exp[3:0]);
            end
        end
    endtask

    task automatic test_load();
        en = 0; up = 1; ld = 0; top = 4'd7;
        do_reset();
        en = 1;
        adv(); adv();
        ld = 1; ldv = 4'd12;
        adv();
        ld = 0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (cnt_o[k] !== 4'd7 || tc_o[k] !== 1'b0) begin
                n_fail++; $display("FAIL load_clamp dut%0d: got cnt=%0d tc=%b exp cnt=7 tc=0", k, cnt_o[k], tc_o[k]);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            adv();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                got = {cnt_o[k], tc_o[k], max_o[k], zero_o[k]};
                exp = {4'(m_cnt[k]), m_tc[k], m_cnt[k] == int'(top), m_cnt[k] == 0};
                if (got !== exp) begin
                    n_fail++; $display("FAIL load dut%0d edge%0d: got %b exp %b", k, i, got, exp);
                end
            end
            if (i == 1) begin
                n_tests++;
                if (cnt_o[0] !== 4'd0 || tc_o[0] !== 1'b1) begin
                    n_fail++; $display("FAIL load_then_wrap: got cnt=%0d tc=%b exp cnt=0 tc=1", cnt_o[0], tc_o[0]);
                end
            end
        end
    endtask

    task automatic test_top_lower();
        for (int dir = 1; dir >= 0; dir--) begin
            en = 0; ld = 0; top = 4'd15;
            do_reset();
            ld = 1; ldv = 4'd8;
            adv();
            ld = 0; top = 4'd4;
            #1;
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (max_o[k] !== 1'b0 || cnt_o[k] !== 4'd8) begin
                    n_fail++; $display("FAIL top_lower_max dut%0d: got max=%b cnt=%0d exp max=0 cnt=8", k, max_o[k], cnt_o[k]);
                end
            end
            en = 1; up = dir[0];
            adv();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                got = {cnt_o[k], tc_o[k], max_o[k], zero_o[k]};
                exp = {4'(m_cnt[k]), m_tc[k], m_cnt[k] == int'(top), m_cnt[k] == 0};
                if (got !== exp) begin
                    n_fail++; $display("FAIL top_lower dut%0d up=%0d: got %b exp %b", k, dir, got, exp);
                end
            end
            n_tests++;
            exp = 7'(dir ? 0 : 7);
            if (cnt_o[0] !== exp[3:0] || cnt_o[1] !== (dir ? 4'd4 : 4'd7)) begin
                n_fail++; $display("FAIL top_lower_const up=%0d: got w=%0d s=%0d exp w=%0d s=%0d",
                                   dir, cnt_o[0], cnt_o[1], exp[3:0], dir ? 4 : 7);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 0; up = 1; ld = 0; top = 4'd15;
        do_reset();
        en = 1;
        repeat (19) adv();
        n_tests++;
        if (cnt_o[2] !== 4'd6) begin
            n_fail++; $display("FAIL async_pre dut2: got cnt=%0d exp 6", cnt_o[2]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            got = {cnt_o[k], tc_o[k], zero_o[k]} ;
            if (got[5:0] !== 6'b0000_0_1) begin
                n_fail++; $display("FAIL async_reset dut%0d: got %b exp 000001 (cnt,tc,zero)", k, got[5:0]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            adv();
            n_tests++;
            exp = 7'((i == 3) ? 1 : 0);
            if (cnt_o[2] !== exp[3:0]) begin
                n_fail++; $display("FAIL async_restart edge%0d: got %0d exp %0d", i, cnt_o[2], exp[3:0]);
            end
        end
    endtask

    task automatic test_random();
        en = 0; up = 1; ld = 0; top = 4'd10;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(3, 0) != 0);
            up  = $urandom_range(1, 0) == 1;
            ld  = ($urandom_range(19, 0) == 0);
            ldv = 4'($urandom_range(15, 0));
            if ($urandom_range(15, 0) == 0) top = 4'($urandom_range(15, 0));
            adv();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                got = {cnt_o[k], tc_o[k], max_o[k], zero_o[k]};
                exp = {4'(m_cnt[k]), m_tc[k], m_cnt[k] == int'(top), m_cnt[k] == 0};
                if (got !== exp) begin
                    n_fail++; $display("FAIL random dut%0d cyc%0d: got %b exp %b", k, i, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down();
        test_prescale();
        test_load();
        test_top_lower();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised up/down counter with a programmable terminal value, synchronous load, wrap or saturate mode and a built-in enable prescaler. Replaces the fixed single-purpose counter in lab timing chains. Provides a count value, level flags for bound detection, and a one-cycle terminal-count pulse for cascading or event generation.

## Interface
Parameters:
- WIDTH, 8, count width in bits (≥2)
- PRESCALE, 1, number of enabled cycles per count step (≥1; 1 = step on every enabled cycle)
- MODE, CNT_WRAP, bound behaviour (CNT_WRAP or CNT_SAT, from counter_pkg)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- EN  in  1  count enable; feeds prescaler
- UP  in  1  direction: 1 = up, 0 = down; sampled on each step
- LD  in  1  synchronous load strobe
- LD_VAL  in  WIDTH  load value
- TOP  in  WIDTH  terminal (maximum) count, runtime-programmable
- CNT  out  WIDTH  registered count
- MAX  out  1  combinational level, CNT == TOP
- ZERO  out  1  combinational level, CNT == 0
- TC  out  1  registered terminal-count pulse

One clock; reset is asynchronous and active-low.

## Operation
- Prescaler count PC, range 0..PRESCALE-1. EN=1: PC advances; step asserted when PC == PRESCALE-1, then PC wraps to 0. EN=0: PC holds, no step.
- Priority per edge: LD > step > hold.
- LD=1: CNT <= min(LD_VAL, TOP); PC <= 0; TC <= 0; no step that cycle regardless of EN.
- Up step, CNT < TOP: CNT <= CNT+1.
- Up step, CNT >= TOP (bound): CNT_WRAP -> CNT <= 0; CNT_SAT -> CNT <= TOP.
- Down step, CNT > 0: CNT <= CNT-1. This includes CNT > TOP after TOP is lowered; the counter decrements normally.
- Down step, CNT == 0 (bound): CNT_WRAP -> CNT <= TOP; CNT_SAT -> CNT <= 0.
- TC <= 1 for exactly the cycle following any step taken at a bound. TC <= 0 otherwise. In CNT_SAT, TC pulses on every step while pinned.
- TOP = 0: every up step is at bound; CNT stays 0 and TC pulses each step. A down step also wraps to TOP = 0.
- All arithmetic is unsigned WIDTH-bit. No internal overflow path exists; bound checks precede +1/-1.

## Timing
- Reset (rst_n=0, any time, asynchronous): CNT=0, PC=0, TC=0. Outputs settle to MAX=(TOP==0), ZERO=1. Reset deassertion is synchronised externally.
- Reset mid-count discards PC progress. The first step after release requires a full PRESCALE enabled cycles.
- Step latency: with EN held high from reset release, the first CNT change occurs at the PRESCALE-th rising edge.
- CNT and TC update on the same edge. TC is high during the cycle in which CNT shows the wrapped or pinned value.
- MAX and ZERO follow CNT/TOP combinationally with no register delay. A TOP change is reflected in MAX within the same cycle.
- UP change takes effect on the next step; PC is unaffected.
- EN dropped mid-prescale: PC freezes and resumes on re-enable. No step is lost or duplicated.

## Structure
- counter_pkg: typedef enum logic {CNT_WRAP=1'b0, CNT_SAT=1'b1} cnt_mode_e; shared by this block and future counter variants.
- PC width: localparam PC_W = (PRESCALE>1) ? $clog2(PRESCALE) : 1, in module.
- Sub-module tick_gen (parameter PRESCALE; ports clk, rst_n, EN, CLR, STEP) owns PC and step generation. prog_counter drives CLR from LD.

## Test plan
- Wrap up, WIDTH=4, TOP=9, PRESCALE=1, EN=1, UP=1 from reset -> CNT 1..9, then 0 on 10th edge. TC=1 only in the cycle CNT=0 after wrap. MAX=1 while CNT=9.
- Down wrap/saturate, TOP=5, UP=0 from CNT=0. CNT_WRAP -> CNT=5, TC pulse. CNT_SAT -> CNT stays 0, TC pulses on every step.
- Prescale, PRESCALE=3, EN=1 for 7 edges -> CNT=1 after edge 3, CNT=2 after edge 6. EN low for 4 cycles after edge 7, then high -> next step 2 edges later; CNT=3.
- Load/clamp, TOP=7: LD=1, LD_VAL=12 with EN=1 step pending -> CNT=7, PC=0, TC=0. Next up step -> CNT=0 (wrap), TC=1.
- TOP lowered, CNT=8, TOP changed to 4. MAX=0 immediately. Next up step -> CNT=0 (wrap) or 4 (sat). Down step instead -> CNT=7.
- Async reset mid-count, rst_n low between edges at CNT=6, PC=1 -> CNT=0, TC=0, ZERO=1 before the next edge. After release, the first step occurs after PRESCALE edges.
